// File: rtl/ex_stage.sv
// MIPS execute stage: combinational ALU, branch-target adder and an iterative
// shift-add multiplier, with a registered EX/MEM-side output bundle.
module ex_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        hit,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] signExImmediate,
    input  logic        RegDst,
    input  logic        ALUSrc,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic [2:0]  ALUOp,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [31:0] nextPC,
    output logic [31:0] aluResultOut,
    output logic [31:0] writeDataOut,
    output logic [4:0]  writeRegOut,
    output logic [31:0] branchTargetOut,
    output logic        zeroOut,
    output logic        MemtoRegOut,
    output logic        RegWriteOut,
    output logic        MemReadOut,
    output logic        MemWriteOut,
    output logic        BranchOut,
    output logic        hitOut,
    output logic        stall
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;

    logic [31:0] aluResult_q, aluResult_d;
    logic [31:0] writeData_q, writeData_d;
    logic [4:0]  writeReg_q, writeReg_d;
    logic [31:0] branchTarget_q, branchTarget_d;
    logic        zero_q, zero_d;
    logic        memtoReg_q, memtoReg_d;
    logic        regWrite_q, regWrite_d;
    logic        memRead_q, memRead_d;
    logic        memWrite_q, memWrite_d;
    logic        branch_q, branch_d;
    logic        hitOut_q, hitOut_d;

    logic [31:0] operandB;
    logic [31:0] aluResult;
    logic [31:0] accStep;
    logic        isMult;
    logic        loadBundle;
    logic        clearEnables;
    logic [31:0] bundleResult;

    // Single-cycle ALU; MULT yields 0 here because the product comes from acc.
    always_comb begin
        operandB  = ALUSrc ? signExImmediate : readData2;
        isMult    = (ALUOp == 3'b010) && (funct == 6'h18);
        aluResult = 32'd0;
        case (ALUOp)
            3'b000: aluResult = readData1 + operandB;
            3'b001: aluResult = readData1 - operandB;
            3'b010: begin
                case (funct)
                    6'h20:   aluResult = readData1 + operandB;
                    6'h22:   aluResult = readData1 - operandB;
                    6'h24:   aluResult = readData1 & operandB;
                    6'h25:   aluResult = readData1 | operandB;
                    6'h2A:   aluResult = {31'd0, $signed(readData1) < $signed(operandB)};
                    default: aluResult = 32'd0;
                endcase
            end
            3'b011:  aluResult = readData1 & operandB;
            3'b100:  aluResult = readData1 | operandB;
            3'b101:  aluResult = {31'd0, $signed(readData1) < $signed(operandB)};
            default: aluResult = 32'd0;
        endcase
    end

    assign accStep = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

    assign stall = ~reset & (((state_q == IDLE) & hit & isMult) |
                             ((state_q == BUSY) & (count_q != 5'd31)));

    // Sequencing of the multiply unit and of the output bundle.
    always_comb begin
        state_d        = state_q;
        mcand_d        = mcand_q;
        mplier_d       = mplier_q;
        acc_d          = acc_q;
        count_d        = count_q;
        aluResult_d    = aluResult_q;
        writeData_d    = writeData_q;
        writeReg_d     = writeReg_q;
        branchTarget_d = branchTarget_q;
        zero_d         = zero_q;
        memtoReg_d     = memtoReg_q;
        regWrite_d     = regWrite_q;
        memRead_d      = memRead_q;
        memWrite_d     = memWrite_q;
        branch_d       = branch_q;
        hitOut_d       = hitOut_q;
        loadBundle     = 1'b0;
        clearEnables   = 1'b0;
        bundleResult   = aluResult;

        case (state_q)
            IDLE: begin
                if (hit && !isMult) begin
                    loadBundle = 1'b1;
                end else if (hit && isMult) begin
                    mcand_d      = readData1;
                    mplier_d     = readData2;
                    acc_d        = 32'd0;
                    count_d      = 5'd0;
                    state_d      = BUSY;
                    clearEnables = 1'b1;
                end else begin
                    clearEnables = 1'b1;
                end
            end
            BUSY: begin
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                acc_d    = accStep;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    loadBundle   = 1'b1;
                    bundleResult = accStep;
                    state_d      = IDLE;
                end else begin
                    clearEnables = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (loadBundle) begin
            aluResult_d    = bundleResult;
            zero_d         = (bundleResult == 32'd0);
            writeData_d    = readData2;
            writeReg_d     = RegDst ? rd : rt;
            branchTarget_d = nextPC + {signExImmediate[29:0], 2'b00};
            memtoReg_d     = MemtoReg;
            regWrite_d     = RegWrite;
            memRead_d      = MemRead;
            memWrite_d     = MemWrite;
            branch_d       = Branch;
            hitOut_d       = 1'b1;
        end
        if (clearEnables) begin
            regWrite_d = 1'b0;
            memRead_d  = 1'b0;
            memWrite_d = 1'b0;
            branch_d   = 1'b0;
            hitOut_d   = 1'b0;
        end
    end

    // Reset aborts any multiply in flight and clears the whole output bundle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            mcand_q        <= 32'd0;
            mplier_q       <= 32'd0;
            acc_q          <= 32'd0;
            count_q        <= 5'd0;
            aluResult_q    <= 32'd0;
            writeData_q    <= 32'd0;
            writeReg_q     <= 5'd0;
            branchTarget_q <= 32'd0;
            zero_q         <= 1'b0;
            memtoReg_q     <= 1'b0;
            regWrite_q     <= 1'b0;
            memRead_q      <= 1'b0;
            memWrite_q     <= 1'b0;
            branch_q       <= 1'b0;
            hitOut_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            mcand_q        <= mcand_d;
            mplier_q       <= mplier_d;
            acc_q          <= acc_d;
            count_q        <= count_d;
            aluResult_q    <= aluResult_d;
            writeData_q    <= writeData_d;
            writeReg_q     <= writeReg_d;
            branchTarget_q <= branchTarget_d;
            zero_q         <= zero_d;
            memtoReg_q     <= memtoReg_d;
            regWrite_q     <= regWrite_d;
            memRead_q      <= memRead_d;
            memWrite_q     <= memWrite_d;
            branch_q       <= branch_d;
            hitOut_q       <= hitOut_d;
        end
    end

    assign aluResultOut    = aluResult_q;
    assign writeDataOut    = writeData_q;
    assign writeRegOut     = writeReg_q;
    assign branchTargetOut = branchTarget_q;
    assign zeroOut         = zero_q;
    assign MemtoRegOut     = memtoReg_q;
    assign RegWriteOut     = regWrite_q;
    assign MemReadOut      = memRead_q;
    assign MemWriteOut     = memWrite_q;
    assign BranchOut       = branch_q;
    assign hitOut          = hitOut_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases, MULT timing, reset abort,
// and randomized instructions checked against an arithmetic reference model.
module tb_ex_stage;

    logic        clock, reset, hit;
    logic [31:0] readData1, readData2, signExImmediate, nextPC;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic [2:0]  ALUOp;
    logic [4:0]  rt, rd;
    logic [5:0]  funct;
    logic [31:0] aluResultOut, writeDataOut, branchTargetOut;
    logic [4:0]  writeRegOut;
    logic        zeroOut, MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut;
    logic        hitOut, stall;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b, imm, pc;
        logic [4:0]  rt, rd;
        logic        regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch;
    } instr_t;

    ex_stage dut (
        .clock(clock), .reset(reset), .hit(hit),
        .readData1(readData1), .readData2(readData2), .signExImmediate(signExImmediate),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .ALUOp(ALUOp), .rt(rt), .rd(rd), .funct(funct), .nextPC(nextPC),
        .aluResultOut(aluResultOut), .writeDataOut(writeDataOut), .writeRegOut(writeRegOut),
        .branchTargetOut(branchTargetOut), .zeroOut(zeroOut),
        .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut),
        .MemWriteOut(MemWriteOut), .BranchOut(BranchOut), .hitOut(hitOut), .stall(stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic instr_t blankInstr();
        instr_t t;
        t.op = 3'd0; t.fn = 6'd0; t.a = 32'd0; t.b = 32'd0; t.imm = 32'd0; t.pc = 32'd0;
        t.rt = 5'd0; t.rd = 5'd0; t.regDst = 1'b0; t.aluSrc = 1'b0; t.memtoReg = 1'b0;
        t.regWrite = 1'b0; t.memRead = 1'b0; t.memWrite = 1'b0; t.branch = 1'b0;
        return t;
    endfunction

    function automatic instr_t multInstr(input logic [31:0] a, input logic [31:0] b);
        instr_t t = blankInstr();
        t.op = 3'b010; t.fn = 6'h18; t.a = a; t.b = b;
        t.regDst = 1'b1; t.rd = 5'd17; t.regWrite = 1'b1;
        t.imm = $urandom(); t.aluSrc = 1'($urandom()); t.pc = 32'h400;
        return t;
    endfunction

    // Reference model: the instruction's meaning in plain arithmetic.
    function automatic logic [31:0] modelResult(input instr_t t);
        logic [31:0] opB = t.aluSrc ? t.imm : t.b;
        logic [31:0] lt  = ($signed(t.a) < $signed(opB)) ? 32'd1 : 32'd0;
        case (t.op)
            3'd0: return t.a + opB;
            3'd1: return t.a - opB;
            3'd2: begin
                if (t.fn == 6'h20) return t.a + opB;
                if (t.fn == 6'h22) return t.a - opB;
                if (t.fn == 6'h24) return t.a & opB;
                if (t.fn == 6'h25) return t.a | opB;
                if (t.fn == 6'h2A) return lt;
                if (t.fn == 6'h18) return t.a * t.b;
                return 32'd0;
            end
            3'd3: return t.a & opB;
            3'd4: return t.a | opB;
            3'd5: return lt;
            default: return 32'd0;
        endcase
    endfunction

    function automatic instr_t randInstr();
        instr_t t = blankInstr();
        t.op = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 5))
            0: t.fn = 6'h20;
            1: t.fn = 6'h22;
            2: t.fn = 6'h24;
            3: t.fn = 6'h25;
            4: t.fn = 6'h2A;
            default: t.fn = 6'($urandom());
        endcase
        if (t.fn == 6'h18) t.fn = 6'h00;
        t.a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
        t.b   = ($urandom_range(0, 3) == 0) ? t.a : $urandom();
        t.imm = $urandom();
        t.pc  = $urandom() & 32'hFFFF_FFFC;
        t.rt = 5'($urandom()); t.rd = 5'($urandom());
        t.regDst = 1'($urandom()); t.aluSrc = 1'($urandom()); t.memtoReg = 1'($urandom());
        t.regWrite = 1'($urandom()); t.memRead = 1'($urandom());
        t.memWrite = 1'($urandom()); t.branch = 1'($urandom());
        return t;
    endfunction

    task automatic applyStimulus(input instr_t t);
        hit = 1'b1;
        readData1 = t.a; readData2 = t.b; signExImmediate = t.imm; nextPC = t.pc;
        ALUOp = t.op; funct = t.fn; rt = t.rt; rd = t.rd;
        RegDst = t.regDst; ALUSrc = t.aluSrc; MemtoReg = t.memtoReg; RegWrite = t.regWrite;
        MemRead = t.memRead; MemWrite = t.memWrite; Branch = t.branch;
    endtask

    task automatic checkOutput(input string tag, input instr_t t);
        logic [31:0] res = modelResult(t);
        check({tag, ".aluResult"}, aluResultOut, res);
        check({tag, ".zero"}, 32'(zeroOut), (res == 32'd0) ? 32'd1 : 32'd0);
        check({tag, ".writeData"}, writeDataOut, t.b);
        check({tag, ".writeReg"}, 32'(writeRegOut), 32'(t.regDst ? t.rd : t.rt));
        check({tag, ".branchTarget"}, branchTargetOut, t.pc + t.imm * 32'd4);
        check({tag, ".ctrl"}, {27'd0, MemtoRegOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut},
              {27'd0, t.memtoReg, t.regWrite, t.memRead, t.memWrite, t.branch});
        check({tag, ".hitOut"}, 32'(hitOut), 32'd1);
    endtask

    task automatic checkBubble(input string tag);
        check({tag, ".bubble"}, {27'd0, hitOut, RegWriteOut, MemReadOut, MemWriteOut, BranchOut}, 32'd0);
    endtask

    task automatic checkReset(input string tag);
        check({tag, ".data"}, aluResultOut | writeDataOut | branchTargetOut | 32'(writeRegOut), 32'd0);
        check({tag, ".flags"}, {24'd0, zeroOut, MemtoRegOut, RegWriteOut, MemReadOut,
                                MemWriteOut, BranchOut, hitOut, stall}, 32'd0);
    endtask

    // One instruction presented in a cycle, checked after the following edge.
    task automatic issueSingle(input string tag, input instr_t t);
        applyStimulus(t);
        #1 check({tag, ".stall"}, 32'(stall), 32'd0);
        @(posedge clock); #1;
        checkOutput(tag, t);
    endtask

    task automatic idleCycle(input string tag, input logic [31:0] held);
        hit = 1'b0;
        @(posedge clock); #1;
        checkBubble(tag);
        check({tag, ".hold"}, aluResultOut, held);
    endtask

    // Full MULT: stall in cycles 0..31, 32 bubble outputs, result after edge 32.
    task automatic runMult(input string tag, input instr_t t);
        applyStimulus(t);
        #1 check({tag, ".stall0"}, 32'(stall), 32'd1);
        for (int c = 1; c <= 32; c++) begin
            @(posedge clock); #1;
            checkBubble(tag);
            check({tag, ".stallN"}, 32'(stall), (c < 32) ? 32'd1 : 32'd0);
        end
        @(posedge clock); #1;
        checkOutput(tag, t);
    endtask

    initial begin
        instr_t t;
        reset = 1'b1;
        applyStimulus(multInstr(32'd3, 32'd4));
        #1 check("resetStall", 32'(stall), 32'd0);
        repeat (2) @(posedge clock);
        #1 checkReset("reset");
        reset = 1'b0;

        t = blankInstr();
        t.op = 3'b010; t.fn = 6'h20; t.a = 32'd5; t.b = 32'd7; t.regDst = 1'b1; t.rd = 5'd9;
        t.regWrite = 1'b1;
        issueSingle("addR", t);
        check("addR.value", aluResultOut, 32'd12);

        t = blankInstr();
        t.op = 3'b001; t.a = 32'h1234; t.b = 32'h1234; t.branch = 1'b1;
        t.pc = 32'h100; t.imm = 32'hFFFF_FFFE;
        issueSingle("beq", t);
        check("beq.target", branchTargetOut, 32'hF8);

        t = blankInstr();
        t.op = 3'b000; t.aluSrc = 1'b1; t.memRead = 1'b1; t.memtoReg = 1'b1;
        t.a = 32'h1000; t.imm = 32'hFFFF_FFFC; t.rt = 5'd3; t.b = 32'hABCD;
        issueSingle("lw", t);
        check("lw.value", aluResultOut, 32'hFFC);
        idleCycle("lwIdle", 32'hFFC);

        runMult("mult7x6", multInstr(32'd7, 32'd6));
        check("mult7x6.value", aluResultOut, 32'd42);
        idleCycle("multPulse", 32'd42);

        runMult("multNeg", multInstr(32'hFFFF_FFFF, 32'd3));
        check("multNeg.value", aluResultOut, 32'hFFFF_FFFD);
        runMult("multWrap", multInstr(32'h8000_0000, 32'd2));
        check("multWrap.zero", 32'(zeroOut), 32'd1);
        idleCycle("multWrapIdle", 32'd0);

        applyStimulus(multInstr(32'd9, 32'd11));
        @(posedge clock);
        for (int c = 1; c <= 9; c++) @(posedge clock);
        #1 reset = 1'b1;
        #1 check("abort.stall", 32'(stall), 32'd0);
        @(posedge clock); #1;
        checkReset("abort");
        reset = 1'b0;
        t = blankInstr();
        t.op = 3'b000; t.a = 32'd100; t.b = 32'd23; t.regWrite = 1'b1; t.rt = 5'd4;
        issueSingle("postAbort", t);

        for (int i = 0; i < 40; i++) begin
            if (i % 10 == 9) begin
                runMult("randMult", multInstr($urandom(), $urandom()));
            end else begin
                issueSingle("rand", randInstr());
            end
            if (i % 7 == 3) idleCycle("randIdle", aluResultOut);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
